// File: rtl/smvm_stream_feeder.sv
// smvm_stream_feeder: serialises a matrix job (header, dense vector, nonzero entries) into the SMVM in_valid word stream
module smvm_stream_feeder #(
  parameter int K = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int START_THRESH = 8,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [11:0] cfg_rows,
  input  logic [11:0] cfg_cols,
  input  logic        vec_valid,
  output logic        vec_ready,
  input  logic [7:0]  vec_data,
  input  logic        ent_valid,
  output logic        ent_ready,
  input  logic [7:0]  ent_val,
  input  logic [11:0] ent_col,
  input  logic        ent_row_end,
  input  logic        ent_last,
  output logic        in_valid,
  output logic [7:0]  val_in,
  output logic        ipv_in,
  output logic [2:0]  col_in,
  output logic        busy,
  output logic        done,
  output logic        err_underrun,
  output logic        err_cfg
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (K > 1) ? $clog2(K) : 1;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [3:0] {IDLE, ROWS, COLS, VEC, FILL, E_VAL, E_IDX, P_VAL, P_IDX, END, DRAIN} state_t;
  typedef struct packed {
    logic [7:0]  val;
    logic [11:0] col;
    logic        row_end;
    logic        last;
  } ent_t;
  state_t state, state_n;
  ent_t mem [FIFO_DEPTH];
  ent_t head;
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt, cnt_n;
  logic [11:0] rows_q, rows_n, cols_q, cols_n, vcnt, vcnt_n, word_q, word_n, hd_col, hd_col_n;
  logic [GW-1:0] g, g_n, g_inc;
  logic [DW-1:0] dcnt, dcnt_n;
  logic last_seen, last_seen_n, hd_last, hd_last_n, err_u_n, err_cfg_n, done_n, iv_n;
  logic push, pop, accept;
  assign push = ent_valid & ent_ready;
  assign pop = state == E_VAL;
  assign accept = cfg_valid & cfg_ready;
  assign head = mem[rp];
  assign g_inc = (g == GW'(K - 1)) ? '0 : g + 1'b1;
  // the FIFO is flushed whenever the feeder sits idle so a truncated job leaves nothing behind
  assign cnt_n = (state == IDLE) ? '0 : cnt + CW'(push) - CW'(pop);
  assign {val_in, ipv_in, col_in} = word_q;
  always_comb begin
    state_n = state;
    rows_n = rows_q;
    cols_n = cols_q;
    vcnt_n = vcnt;
    dcnt_n = dcnt;
    g_n = g;
    hd_col_n = hd_col;
    hd_last_n = hd_last;
    last_seen_n = last_seen | (push & ent_last);
    err_u_n = err_underrun;
    err_cfg_n = 1'b0;
    done_n = 1'b0;
    iv_n = 1'b0;
    word_n = '0;
    case (state)
      IDLE: begin
        last_seen_n = 1'b0;
        g_n = '0;
        if (accept && (cfg_rows == '0 || cfg_cols == '0)) err_cfg_n = 1'b1;
        else if (accept) begin
          rows_n = cfg_rows;
          cols_n = cfg_cols;
          vcnt_n = '0;
          err_u_n = 1'b0;
          state_n = ROWS;
        end
      end
      ROWS: begin
        iv_n = 1'b1;
        word_n = rows_q;
        state_n = COLS;
      end
      COLS: begin
        iv_n = 1'b1;
        word_n = cols_q;
        state_n = VEC;
      end
      VEC: begin
        iv_n = 1'b1;
        word_n = {vec_valid ? vec_data : 8'd0, 4'd0};
        err_u_n = err_underrun | ~vec_valid;
        vcnt_n = vcnt + 1'b1;
        state_n = (vcnt == cols_q - 12'd1) ? FILL : VEC;
      end
      FILL: state_n = (cnt >= CW'(START_THRESH) || last_seen) ? E_VAL : FILL;
      E_VAL: begin
        iv_n = 1'b1;
        word_n = {head.val, head.row_end, 3'b000};
        hd_col_n = head.col;
        hd_last_n = head.last;
        state_n = E_IDX;
      end
      E_IDX: begin
        iv_n = 1'b1;
        word_n = hd_col;
        g_n = g_inc;
        state_n = (hd_last || cnt == '0) ? ((g_inc == '0) ? END : P_VAL) : E_VAL;
        if (!hd_last && cnt == '0) begin
          err_u_n = 1'b1;
          last_seen_n = 1'b1;
        end
      end
      P_VAL: begin
        iv_n = 1'b1;
        state_n = P_IDX;
      end
      P_IDX: begin
        iv_n = 1'b1;
        g_n = g_inc;
        state_n = (g_inc == '0) ? END : P_VAL;
      end
      END: begin
        dcnt_n = '0;
        state_n = DRAIN;
      end
      DRAIN: begin
        dcnt_n = dcnt + 1'b1;
        done_n = dcnt == DW'(DRAIN_CYCLES - 1);
        state_n = done_n ? IDLE : DRAIN;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= '{ent_val, ent_col, ent_row_end, ent_last};
  end
  // outputs are registered from the next-state view, so handshake readies match the state they guard
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      rows_q <= '0;
      cols_q <= '0;
      vcnt <= '0;
      dcnt <= '0;
      g <= '0;
      hd_col <= '0;
      hd_last <= 1'b0;
      last_seen <= 1'b0;
      word_q <= '0;
      in_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err_underrun <= 1'b0;
      err_cfg <= 1'b0;
      cfg_ready <= 1'b0;
      vec_ready <= 1'b0;
      ent_ready <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      wp <= (state == IDLE) ? '0 : wp + AW'(push);
      rp <= (state == IDLE) ? '0 : rp + AW'(pop);
      rows_q <= rows_n;
      cols_q <= cols_n;
      vcnt <= vcnt_n;
      dcnt <= dcnt_n;
      g <= g_n;
      hd_col <= hd_col_n;
      hd_last <= hd_last_n;
      last_seen <= last_seen_n;
      word_q <= word_n;
      in_valid <= iv_n;
      busy <= state_n != IDLE;
      done <= done_n;
      err_underrun <= err_u_n;
      err_cfg <= err_cfg_n;
      cfg_ready <= state_n == IDLE;
      vec_ready <= state_n == VEC;
      ent_ready <= (cnt_n != CW'(FIFO_DEPTH)) && !last_seen_n && (state_n inside {VEC, FILL, E_VAL, E_IDX});
    end
  end
endmodule
